// File: rtl/dlatch_rst_pkg.sv
// Shared defaults for the reset-able transparent latch.
package dlatch_rst_pkg;

    localparam int unsigned DLATCH_DEFAULT_WIDTH   = 1;
    localparam logic        DLATCH_DEFAULT_RST_BIT = 1'b0;

endpackage

// File: rtl/dlatch_rst_bit.sv
// Single-bit level-sensitive latch: transparent while clk is high, async reset wins.
module dlatch_rst_bit
    import dlatch_rst_pkg::*;
#(
    parameter logic RST_VAL = DLATCH_DEFAULT_RST_BIT
) (
    input  logic d,
    input  logic clk,
    input  logic rst,
    output logic q
);

    logic latch_q;

    // Storage is a true latch on purpose; clk acts as the enable, not an edge.
    always_latch begin
        if (rst) begin
            latch_q <= RST_VAL;
        end else if (clk) begin
            latch_q <= d;
        end
    end

    assign q = latch_q;

endmodule

// File: rtl/dlatch_rst.sv
// WIDTH-bit latch with async active-high reset, built from independent bit slices.
module dlatch_rst
    import dlatch_rst_pkg::*;
#(
    parameter int unsigned          WIDTH   = DLATCH_DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0]     RST_VAL = {WIDTH{DLATCH_DEFAULT_RST_BIT}}
) (
    input  logic [WIDTH-1:0] d,
    input  logic             clk,
    input  logic             rst,
    output logic [WIDTH-1:0] q
);

    if (WIDTH < 1) begin : g_bad_width
        $error("dlatch_rst: WIDTH must be at least 1");
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        dlatch_rst_bit #(
            .RST_VAL (RST_VAL[i])
        ) u_bit (
            .d   (d[i]),
            .clk (clk),
            .rst (rst),
            .q   (q[i])
        );
    end

endmodule

// File: tb/tb_dlatch_rst.sv
// Directed checks of the default 1-bit latch and an 8-bit build with a non-zero reset value.
module tb_dlatch_rst;

    typedef struct {
        logic rst;
        logic clk;
        logic d;
        logic exp_q;
        string name;
    } vec_t;

    logic       clk, rst, d1;
    logic       q1;
    logic       clk8, rst8;
    logic [7:0] d8, q8;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    dlatch_rst u_dut1 (
        .d   (d1),
        .clk (clk),
        .rst (rst),
        .q   (q1)
    );

    dlatch_rst #(
        .WIDTH   (8),
        .RST_VAL (8'hA5)
    ) u_dut8 (
        .d   (d8),
        .clk (clk8),
        .rst (rst8),
        .q   (q8)
    );

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: q=%h expected %h", name, got, exp);
        end
    endtask

    vec_t vecs[$];

    initial begin
        clk  = 1'b0; rst  = 1'b0; d1 = 1'b0;
        clk8 = 1'b0; rst8 = 1'b0; d8 = 8'h00;
        #5;

        // Reset held for 20 time units with clk low.
        rst = 1'b1;
        #1 check("reset_assert", {7'd0, q1}, 8'h00);
        #19 check("reset_held", {7'd0, q1}, 8'h00);

        vecs = '{
            '{1'b0, 1'b0, 1'b0, 1'b0, "release_clk0"},
            '{1'b0, 1'b1, 1'b1, 1'b1, "transp_d1"},
            '{1'b0, 1'b1, 1'b0, 1'b0, "transp_d0"},
            '{1'b0, 1'b1, 1'b1, 1'b1, "transp_d1b"},
            '{1'b0, 1'b0, 1'b1, 1'b1, "fall_hold1"},
            '{1'b0, 1'b0, 1'b0, 1'b1, "hold_ignore_d"},
            '{1'b0, 1'b1, 1'b0, 1'b0, "reopen_d0"},
            '{1'b0, 1'b0, 1'b0, 1'b0, "fall_hold0"},
            '{1'b0, 1'b0, 1'b1, 1'b0, "hold0_ignore_d"},
            '{1'b0, 1'b1, 1'b1, 1'b1, "reopen_d1"},
            '{1'b1, 1'b1, 1'b1, 1'b0, "rst_mid_transp"},
            '{1'b1, 1'b1, 1'b0, 1'b0, "rst_d_toggle0"},
            '{1'b1, 1'b1, 1'b1, 1'b0, "rst_d_toggle1"},
            '{1'b0, 1'b1, 1'b1, 1'b1, "release_clk1"},
            '{1'b1, 1'b0, 1'b1, 1'b0, "rst_clk_low"},
            '{1'b0, 1'b0, 1'b1, 1'b0, "release_clk0_keep"},
            '{1'b0, 1'b1, 1'b1, 1'b1, "next_transp"}
        };

        for (int i = 0; i < vecs.size(); i++) begin
            rst = vecs[i].rst;
            clk = vecs[i].clk;
            d1  = vecs[i].d;
            #1 check(vecs[i].name, {7'd0, q1}, {7'd0, vecs[i].exp_q});
            #4;
        end

        // d and clk rising in the same timestep: new d must be taken.
        clk = 1'b0;
        #5 d1 = 1'b1;
        #5 check("pre_same_step", {7'd0, q1}, 8'h01);
        clk = 1'b1; d1 = 1'b0;
        #1 check("same_step_rise", {7'd0, q1}, 8'h00);
        #4 clk = 1'b0;

        // 8-bit build with non-zero reset value.
        rst8 = 1'b1;
        #1 check("w8_reset", q8, 8'hA5);
        #4 d8 = 8'h3C;
        #1 check("w8_reset_ignore_d", q8, 8'hA5);
        #4 rst8 = 1'b0;
        #1 check("w8_release_clk0", q8, 8'hA5);
        #4 clk8 = 1'b1;
        #1 check("w8_transp", q8, 8'h3C);
        #4 clk8 = 1'b0;
        #5 d8 = 8'hFF;
        #1 check("w8_hold", q8, 8'h3C);
        #4 d8 = 8'h5A; clk8 = 1'b1;
        #1 check("w8_bits_indep", q8, 8'h5A);
        #4 rst8 = 1'b1;
        #1 check("w8_rst_mid_transp", q8, 8'hA5);
        #4 rst8 = 1'b0;
        #1 check("w8_release_clk1", q8, 8'h5A);

        #5;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/dlatch_rst.md
DLATCH_RST -- requirements
Module: dlatch_rst

Interface
REQ-001 Parameter WIDTH, default 1: bit width of d and q.
REQ-002 Parameter RST_VAL, default all-zeros (WIDTH bits): value forced onto q while reset is asserted.
REQ-003 Port clk, input, 1 bit: the one clock, used as the level-sensitive latch enable; high = transparent, low = hold.
REQ-004 Port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 Port d, input, WIDTH bits: data input.
REQ-006 Port q, output, WIDTH bits: latched data output.
REQ-007 Positional port order SHALL be d, clk, rst, q; instances connect by position.
REQ-008 Defaults SHALL give a 1-bit latch whose reset value is 0.

Function
REQ-009 rst=1: q SHALL equal RST_VAL immediately, independent of clk and d.
REQ-010 rst=0 and clk=1: q SHALL follow d combinationally, with zero clock latency.
REQ-011 rst=0 and clk=0: q SHALL hold the value present at the clk falling edge; d changes SHALL be ignored.
REQ-012 d and clk changing in the same timestep to clk=1: q SHALL take the new d.
REQ-013 d and clk changing in the same timestep to clk=0: the captured value is undefined; users SHALL keep d stable around the falling edge.
REQ-014 Reset mid-transparent phase: q SHALL go to RST_VAL and stay there while rst=1, even if d toggles.
REQ-015 rst falling while clk=0: q SHALL keep RST_VAL until the next transparent phase.
REQ-016 rst falling while clk=1: q SHALL take d in the same timestep.
REQ-017 Before the first reset or transparent phase, q is unspecified (X in simulation).
REQ-018 Each bit SHALL behave independently; there is no cross-bit logic.
REQ-019 The design SHALL infer a level-sensitive latch with async reset, not a flip-flop; no edge-triggered storage is permitted.

Reset
REQ-020 Reset SHALL be asynchronous and active-high on rst, with rst taking priority over clk.
REQ-021 The reset value of q SHALL be RST_VAL, which is 0 by default.
REQ-022 Reset deassertion SHALL NOT by itself load d; loading requires clk=1.

Structure
REQ-023 A shared package SHALL hold the default WIDTH constant and the RST_VAL default constant; no typedefs are needed.
REQ-024 One sub-module, dlatch_rst_bit, SHALL be used: a 1-bit latch with async reset, instantiated WIDTH times by a generate loop.
REQ-025 The top level SHALL contain only the generate loop and parameter checks; WIDTH < 1 is a compile-time error.
REQ-026 The RTL SHALL be lint-clean, with the latch inference intentional and waived locally.

Verification
REQ-027 Reset: d=0, clk=0; rst 0->1 for 20 time units -> q=0; rst->0 with clk=0 -> q stays 0.
REQ-028 Transparency: clk=1, d=1 -> q=1 in the same timestep; toggle d 1->0->1 with clk high -> q tracks each change.
REQ-029 Hold: q=1; clk->0; d->0 -> q stays 1. Then clk=1 with d=0 -> q=0. Then clk->0 -> q holds 0.
REQ-030 Reset priority: clk=1, d=1, q=1; rst=1 -> q=0 immediately; toggle d while rst=1 -> q stays 0.
REQ-031 Release with clk=1: rst 1->0 while clk=1, d=1 -> q=1. Release with clk=0: rst 1->0 -> q stays 0.
REQ-032 Parameterised build: WIDTH=8, RST_VAL=8'hA5; reset -> q=8'hA5; clk=1, d=8'h3C -> q=8'h3C; clk=0, d=8'hFF -> q holds 8'h3C.
